// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory freeze.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
//
// state      | meaning
// IDLE       | normal flow; a load-use hazard inserts the first bubble here
// LOAD_STALL | remaining LOAD_LAT-1 bubbles of a load-use hazard
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_if_id_rs,
  input  logic [REG_ADDR_W-1:0] i_if_id_rt,
  input  logic                  i_if_id_uses_rt,
  input  logic [REG_ADDR_W-1:0] i_id_ex_rt,
  input  logic                  i_id_ex_memread,
  input  logic                  i_branch_taken,
  input  logic                  i_mem_busy,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_id_ex_write,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_flush,
  output logic                  o_stall_active,
  output logic [31:0]           o_stall_stat,
  output logic [31:0]           o_flush_stat
);

  typedef enum logic {IDLE, LOAD_STALL} state_t;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LOAD_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hazard;
  logic             w_bubble;

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign w_hazard = i_id_ex_memread && (i_id_ex_rt != '0) &&
                    ((i_id_ex_rt == i_if_id_rs) ||
                     (i_if_id_uses_rt && (i_id_ex_rt == i_if_id_rt)));

  always_comb begin
    o_pc_write    = 1'b1;
    o_if_id_write = 1'b1;
    o_id_ex_write = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    w_bubble      = 1'b0;
    if (i_mem_busy) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_id_ex_write = 1'b0;
    end else if (i_branch_taken) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if ((r_state == LOAD_STALL) || w_hazard) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_id_ex_flush = 1'b1;
      w_bubble      = 1'b1;
    end
  end

  assign o_stall_active = (r_state == LOAD_STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (!i_mem_busy) begin
      if (i_branch_taken) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == LOAD_STALL) begin
        if (r_cnt == CNT_W'(1)) r_state <= IDLE;
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (w_hazard && (LOAD_LAT > 1)) begin
        r_state <= LOAD_STALL;
        r_cnt   <= LAT_M1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_stat;
  logic [31:0] r_flush_stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_stat <= '0;
      r_flush_stat <= '0;
    end else begin
      if (w_bubble && (r_stall_stat != '1)) r_stall_stat <= r_stall_stat + 32'd1;
      if (!i_mem_busy && i_branch_taken && (r_flush_stat != '1))
        r_flush_stat <= r_flush_stat + 32'd1;
    end
  end

  assign o_stall_stat = r_stall_stat;
  assign o_flush_stat = r_flush_stat;
`else
  assign o_stall_stat = 32'd0;
  assign o_flush_stat = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (LOAD_LAT 1..3) on shared stimulus,
// checked every cycle against a bubble-count model plus directed literal checks.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, ex_rt;
  logic       uses_rt, memrd, br, busy;

  logic [2:0]  pcw, ifidw, idexw, ififl, idexfl, sa;
  logic [31:0] sstat [3];
  logic [31:0] fstat [3];

  int checks   = 0;
  int failures = 0;

  int rem   [3];
  int m_sst [3];
  int m_fst [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_LAT(g + 1), .CNT_W(4)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_if_id_rs     (rs),
      .i_if_id_rt     (rt),
      .i_if_id_uses_rt(uses_rt),
      .i_id_ex_rt     (ex_rt),
      .i_id_ex_memread(memrd),
      .i_branch_taken (br),
      .i_mem_busy     (busy),
      .o_pc_write     (pcw[g]),
      .o_if_id_write  (ifidw[g]),
      .o_id_ex_write  (idexw[g]),
      .o_if_id_flush  (ififl[g]),
      .o_id_ex_flush  (idexfl[g]),
      .o_stall_active (sa[g]),
      .o_stall_stat   (sstat[g]),
      .o_flush_stat   (fstat[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef HAZARD_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  // Model: rem = bubbles still owed after the current one; a new hazard owes LOAD_LAT-1 more.
  always @(negedge clk) begin
    logic hz, e_pc, e_ifw, e_idw, e_iff, e_idf, e_sa;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        rem[k] = 0; m_sst[k] = 0; m_fst[k] = 0;
      end
      hz = memrd && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
      e_pc = 1; e_ifw = 1; e_idw = 1; e_iff = 0; e_idf = 0;
      e_sa = (rem[k] > 0);
      if (busy) begin
        e_pc = 0; e_ifw = 0; e_idw = 0;
      end else if (br) begin
        e_iff = 1; e_idf = 1;
      end else if (rem[k] > 0 || hz) begin
        e_pc = 0; e_ifw = 0; e_idf = 1;
      end
      chk($sformatf("L%0d pc_write", k+1), pcw[k], e_pc);
      chk($sformatf("L%0d if_id_write", k+1), ifidw[k], e_ifw);
      chk($sformatf("L%0d id_ex_write", k+1), idexw[k], e_idw);
      chk($sformatf("L%0d if_id_flush", k+1), ififl[k], e_iff);
      chk($sformatf("L%0d id_ex_flush", k+1), idexfl[k], e_idf);
      chk($sformatf("L%0d stall_active", k+1), sa[k], e_sa);
      chk($sformatf("L%0d stall_stat", k+1), sstat[k], stat_exp(m_sst[k]));
      chk($sformatf("L%0d flush_stat", k+1), fstat[k], stat_exp(m_fst[k]));
      if (rst_n && !busy) begin
        if (br) begin
          rem[k] = 0; m_fst[k]++;
        end else if (rem[k] > 0) begin
          rem[k]--; m_sst[k]++;
        end else if (hz) begin
          rem[k] = k; m_sst[k]++;
        end
      end
    end
  end

  task automatic step(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_uses,
                      input logic [4:0] a_ex, input logic a_mr, input logic a_br, input logic a_busy);
    @(posedge clk); #1;
    rs = a_rs; rt = a_rt; uses_rt = a_uses; ex_rt = a_ex; memrd = a_mr; br = a_br; busy = a_busy;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic haz5();
    step(5, 0, 0, 5, 1, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rs = 0; rt = 0; uses_rt = 0; ex_rt = 0; memrd = 0; br = 0; busy = 0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset pc_write", pcw[k], 1);
      chk("reset if_id_write", ifidw[k], 1);
      chk("reset id_ex_flush", idexfl[k], 0);
      chk("reset stall_active", sa[k], 0);
      chk("reset stall_stat", sstat[k], 0);
    end
    #1 rst_n = 1'b1;

    // single load-use on rs
    haz5();
    chk("A0 L1 pc_write", pcw[0], 0);
    chk("A0 L1 if_id_write", ifidw[0], 0);
    chk("A0 L1 id_ex_flush", idexfl[0], 1);
    chk("A0 L1 stall_active", sa[0], 0);
    chk("A0 L3 pc_write", pcw[2], 0);
    idle();
    chk("A1 L1 pc_write", pcw[0], 1);
    chk("A1 L1 id_ex_flush", idexfl[0], 0);
    chk("A1 L3 stall_active", sa[2], 1);
    chk("A1 L3 pc_write", pcw[2], 0);
    chk("A1 L2 stall_active", sa[1], 1);
    idle();
    chk("A2 L3 stall_active", sa[2], 1);
    chk("A2 L2 pc_write", pcw[1], 1);
    chk("A2 L2 stall_active", sa[1], 0);
    idle();
    chk("A3 L3 pc_write", pcw[2], 1);
    chk("A3 L3 stall_active", sa[2], 0);

    // hazard on rt, then rt ignored when not a source
    step(3, 7, 1, 7, 1, 0, 0);
    chk("B0 L3 id_ex_flush", idexfl[2], 1);
    idle(); idle(); idle();
    chk("B3 L3 pc_write", pcw[2], 1);
    step(3, 7, 0, 7, 1, 0, 0);
    chk("B4 L3 pc_write", pcw[2], 1);
    chk("B4 L1 pc_write", pcw[0], 1);

    // register zero destination
    step(0, 0, 1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("Z pc_write", pcw[k], 1);
      chk("Z if_id_write", ifidw[k], 1);
      chk("Z id_ex_flush", idexfl[k], 0);
    end

    // branch in second stall cycle aborts stall
    haz5();
    step(0, 0, 0, 0, 0, 1, 0);
    chk("C1 L3 pc_write", pcw[2], 1);
    chk("C1 L3 if_id_flush", ififl[2], 1);
    chk("C1 L3 id_ex_flush", idexfl[2], 1);
    idle();
    chk("C2 L3 pc_write", pcw[2], 1);
    chk("C2 L3 stall_active", sa[2], 0);
    chk("C2 L3 id_ex_flush", idexfl[2], 0);

    // mem_busy freezes a stall in progress; branch/hazard ignored while busy
    haz5();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) step(5, 0, 0, 5, 1, 1, 1);
      else        step(0, 0, 0, 0, 0, 0, 1);
      chk("D busy L2 pc_write", pcw[1], 0);
      chk("D busy L2 if_id_write", ifidw[1], 0);
      chk("D busy L2 id_ex_write", idexw[1], 0);
      chk("D busy L2 if_id_flush", ififl[1], 0);
      chk("D busy L2 id_ex_flush", idexfl[1], 0);
    end
    idle();
    chk("D5 L2 stall_active", sa[1], 1);
    chk("D5 L2 pc_write", pcw[1], 0);
    chk("D5 L2 id_ex_flush", idexfl[1], 1);
    idle();
    chk("D6 L2 pc_write", pcw[1], 1);
    chk("D6 L2 stall_active", sa[1], 0);
    chk("D6 L3 pc_write", pcw[2], 0);
    idle();
    chk("D7 L3 pc_write", pcw[2], 1);

    // statistics from a clean reset
    rst_n = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    haz5(); idle(); idle();
    haz5(); idle(); idle();
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("S L3 stall_stat", sstat[2], stat_exp(6));
    chk("S L3 flush_stat", fstat[2], stat_exp(1));
    chk("S L1 stall_stat", sstat[0], stat_exp(2));

    // asynchronous reset in the middle of a stall
    haz5();
    idle();
    chk("R pre L3 stall_active", sa[2], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("R L3 pc_write", pcw[2], 1);
    chk("R L3 if_id_write", ifidw[2], 1);
    chk("R L3 id_ex_flush", idexfl[2], 0);
    chk("R L3 stall_active", sa[2], 0);
    chk("R L3 stall_stat", sstat[2], 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    idle();
    chk("R post L3 pc_write", pcw[2], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
